qed_replay_scheduler: RTL and testbench
=======================================

Name: qed_replay_scheduler

Overview:
- Sequences the SQED instruction stream.
- Phase ORIG: passes fetched original instructions downstream and buffers each one in a replay FIFO.
- Phase DUP: after the formal tool asserts exec_dup, replays the buffered instructions in program order with qed_is_dup=1. qed_is_dup steers them through the register/immediate remapping path before decode.
- Phase DONE: signals when the original and duplicate counts match, which enables the QED consistency check.

Parameters:
- DEPTH, 8, replay FIFO entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of the orig_cnt and dup_cnt counters.
- NOP_INST, 32'h00000013, instruction driven when no valid output is present (addi x0,x0,0).

Ports:
- clk  input  1  core clock, rising edge.
- reset_x  input  1  asynchronous, active-low reset.
- ifu_inst  input  32  fetched original instruction.
- ifu_valid  input  1  ifu_inst is valid.
- ifu_ready  output  1  fetch handshake; combinational.
- stall  input  1  downstream stall; output registers hold while high.
- exec_dup  input  1  request to start the duplicate phase (free formal input).
- qed_inst  output  32  registered instruction to the decode mux.
- qed_valid  output  1  qed_inst is valid.
- qed_is_dup  output  1  qed_inst is a replayed duplicate; selects the modified path.
- qed_ready  output  1  registered QED check enable.
- orig_cnt  output  CNT_W  originals accepted.
- dup_cnt  output  CNT_W  duplicates issued.

Behaviour:
- Reset (async, reset_x=0):
  - state=ORIG; FIFO empty; rd_ptr=wr_ptr=0.
  - qed_inst=NOP_INST; qed_valid=0; qed_is_dup=0; qed_ready=0; orig_cnt=dup_cnt=0.
  - Reset mid-replay discards FIFO contents and returns to ORIG.
- States: ORIG, DUP, DONE (2-bit encoding). DONE is terminal until reset.
- ifu_ready = (state==ORIG) & !stall & !full & !exec_dup.
- Accept = ifu_valid & ifu_ready. On accept:
  - qed_inst<=ifu_inst; qed_valid<=1; qed_is_dup<=0.
  - Push ifu_inst at wr_ptr; orig_cnt++.
  - Latency: 1 cycle, fetch to qed_inst.
- ORIG with !stall and no accept: qed_valid<=0; qed_inst<=NOP_INST.
- ORIG->DUP: exec_dup & !stall & orig_cnt!=0.
  - exec_dup takes priority over a same-cycle ifu_valid; that instruction is not accepted.
  - exec_dup with an empty FIFO is ignored; state stays ORIG.
- FIFO full in ORIG: ifu_ready=0; remains in ORIG until exec_dup (see Optional Feature).
- DUP, each !stall cycle: pop the FIFO entry at rd_ptr.
  - qed_inst<=entry; qed_valid<=1; qed_is_dup<=1; dup_cnt++.
  - The pop that empties the FIFO moves state to DUP->DONE at the same edge.
- DONE:
  - qed_valid<=0; qed_is_dup<=0; qed_inst<=NOP_INST.
  - qed_ready<=(orig_cnt==dup_cnt); stays asserted while in DONE.
- stall=1: all output registers, pointers, counters and state hold. exec_dup is ignored in that cycle (not latched).
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - full = (count==DEPTH); empty = (count==0); count is a separate CNT_W-bit occupancy register.
- orig_cnt never exceeds DEPTH; counters do not wrap.
- Push and pop never occur in the same cycle; the ORIG and DUP phases are exclusive.

Optional Feature:
- Macro QED_AUTO_DUP_EN.
- Defined: in ORIG, when the FIFO becomes full (count==DEPTH after a push), the next !stall cycle transitions to DUP without exec_dup, so fetch never deadlocks.
- Undefined: a full FIFO only deasserts ifu_ready; the transition requires exec_dup.

Test Plan:
- Reset, then 3 accepts (0x00100093, 0x00208113, 0x002081B3), then exec_dup -> qed_inst shows the three with is_dup=0, then the same three in order with is_dup=1 and dup_cnt=1,2,3. Next cycle: DONE, qed_ready=1, orig_cnt=dup_cnt=3.
- exec_dup at reset with ifu_valid=0 -> state stays ORIG; qed_valid=0; qed_ready stays 0.
- ifu_valid and exec_dup in the same cycle after 1 accept -> second instruction not accepted (ifu_ready=0); replay outputs 1 duplicate; orig_cnt=1.
- stall held 4 cycles during DUP after the first pop -> qed_inst and dup_cnt frozen; replay resumes in order afterwards; no entry lost or repeated.
- Fill DEPTH=8 entries -> ifu_ready=0 on the 9th. With QED_AUTO_DUP_EN: DUP begins the next cycle. Without it: stays ORIG until exec_dup. Pointer wrap verified over 2 resets.
- reset_x pulsed low mid-DUP (after 2 of 5 pops) -> asynchronous clear; qed_inst=0x00000013; counters 0; state ORIG.

Source files
------------

// File: rtl/qed_replay_scheduler.sv
// SQED instruction sequencer: forwards and buffers originals, replays them as duplicates, then arms the QED check.
// Optional macro QED_AUTO_DUP_EN: a full replay FIFO starts the duplicate phase without exec_dup.
module qed_replay_scheduler #(
  parameter int          DEPTH    = 8,
  parameter int          CNT_W    = $clog2(DEPTH) + 1,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic             clk,
  input  logic             reset_x,
  input  logic [31:0]      ifu_inst,
  input  logic             ifu_valid,
  output logic             ifu_ready,
  input  logic             stall,
  input  logic             exec_dup,
  output logic [31:0]      qed_inst,
  output logic             qed_valid,
  output logic             qed_is_dup,
  output logic             qed_ready,
  output logic [CNT_W-1:0] orig_cnt,
  output logic [CNT_W-1:0] dup_cnt
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [1:0] ST_ORIG = 2'd0;
  localparam logic [1:0] ST_DUP  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_orig_cnt;
  logic [CNT_W-1:0] r_dup_cnt;
  logic [31:0]      r_qed_inst;
  logic             r_qed_valid;
  logic             r_qed_is_dup;
  logic             r_qed_ready;
  logic [31:0]      r_mem [DEPTH];

  logic [1:0]       w_state_nxt;
  logic [PTR_W-1:0] w_wr_ptr_nxt;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic [CNT_W-1:0] w_orig_cnt_nxt;
  logic [CNT_W-1:0] w_dup_cnt_nxt;
  logic [31:0]      w_qed_inst_nxt;
  logic             w_qed_valid_nxt;
  logic             w_qed_is_dup_nxt;
  logic             w_qed_ready_nxt;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  logic             w_accept;
  logic             w_go_dup;
  logic [31:0]      w_rd_data;

  assign w_full    = (r_count == CNT_FULL);
  assign w_empty   = (r_count == CNT_ZERO);
  assign ifu_ready = (r_state == ST_ORIG) & ~stall & ~w_full & ~exec_dup;
  assign w_accept  = ifu_valid & ifu_ready;
  assign w_rd_data = r_mem[r_rd_ptr];

`ifdef QED_AUTO_DUP_EN
  assign w_go_dup = (exec_dup & (r_orig_cnt != CNT_ZERO)) | w_full;
`else
  assign w_go_dup = exec_dup & (r_orig_cnt != CNT_ZERO);
`endif

  // Next-state logic for the phase FSM, FIFO bookkeeping and output registers
  always_comb begin
    w_state_nxt      = r_state;
    w_wr_ptr_nxt     = r_wr_ptr;
    w_rd_ptr_nxt     = r_rd_ptr;
    w_count_nxt      = r_count;
    w_orig_cnt_nxt   = r_orig_cnt;
    w_dup_cnt_nxt    = r_dup_cnt;
    w_qed_inst_nxt   = r_qed_inst;
    w_qed_valid_nxt  = r_qed_valid;
    w_qed_is_dup_nxt = r_qed_is_dup;
    w_qed_ready_nxt  = r_qed_ready;
    w_push           = 1'b0;
    if (!stall) begin
      case (r_state)
        ST_ORIG: begin
          w_qed_is_dup_nxt = 1'b0;
          if (w_accept) begin
            w_push          = 1'b1;
            w_qed_inst_nxt  = ifu_inst;
            w_qed_valid_nxt = 1'b1;
            w_wr_ptr_nxt    = r_wr_ptr + PTR_ONE;
            w_count_nxt     = r_count + CNT_ONE;
            w_orig_cnt_nxt  = r_orig_cnt + CNT_ONE;
          end else begin
            w_qed_inst_nxt  = NOP_INST;
            w_qed_valid_nxt = 1'b0;
          end
          if (w_go_dup) begin
            w_state_nxt = ST_DUP;
          end else begin
            w_state_nxt = ST_ORIG;
          end
        end
        ST_DUP: begin
          if (!w_empty) begin
            w_qed_inst_nxt   = w_rd_data;
            w_qed_valid_nxt  = 1'b1;
            w_qed_is_dup_nxt = 1'b1;
            w_rd_ptr_nxt     = r_rd_ptr + PTR_ONE;
            w_count_nxt      = r_count - CNT_ONE;
            w_dup_cnt_nxt    = r_dup_cnt + CNT_ONE;
            // The pop that drains the last entry also closes the phase
            if (r_count == CNT_ONE) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_state_nxt = ST_DUP;
            end
          end else begin
            w_state_nxt      = ST_DONE;
            w_qed_inst_nxt   = NOP_INST;
            w_qed_valid_nxt  = 1'b0;
            w_qed_is_dup_nxt = 1'b0;
          end
        end
        ST_DONE: begin
          w_qed_inst_nxt   = NOP_INST;
          w_qed_valid_nxt  = 1'b0;
          w_qed_is_dup_nxt = 1'b0;
          w_qed_ready_nxt  = (r_orig_cnt == r_dup_cnt);
        end
        default: begin
          w_state_nxt      = ST_ORIG;
          w_qed_inst_nxt   = NOP_INST;
          w_qed_valid_nxt  = 1'b0;
          w_qed_is_dup_nxt = 1'b0;
          w_qed_ready_nxt  = 1'b0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      r_state      <= ST_ORIG;
      r_wr_ptr     <= PTR_ZERO;
      r_rd_ptr     <= PTR_ZERO;
      r_count      <= CNT_ZERO;
      r_orig_cnt   <= CNT_ZERO;
      r_dup_cnt    <= CNT_ZERO;
      r_qed_inst   <= NOP_INST;
      r_qed_valid  <= 1'b0;
      r_qed_is_dup <= 1'b0;
      r_qed_ready  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_count      <= w_count_nxt;
      r_orig_cnt   <= w_orig_cnt_nxt;
      r_dup_cnt    <= w_dup_cnt_nxt;
      r_qed_inst   <= w_qed_inst_nxt;
      r_qed_valid  <= w_qed_valid_nxt;
      r_qed_is_dup <= w_qed_is_dup_nxt;
      r_qed_ready  <= w_qed_ready_nxt;
    end
  end

  // Replay storage; contents are don't-care once the occupancy count is cleared
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= ifu_inst;
    end
  end

  assign qed_inst   = r_qed_inst;
  assign qed_valid  = r_qed_valid;
  assign qed_is_dup = r_qed_is_dup;
  assign qed_ready  = r_qed_ready;
  assign orig_cnt   = r_orig_cnt;
  assign dup_cnt    = r_dup_cnt;

endmodule

// File: tb/tb_qed_replay_scheduler.sv
// Directed self-checking bench for qed_replay_scheduler (DEPTH=8); follows QED_AUTO_DUP_EN when defined.
module tb_qed_replay_scheduler;

  logic        clk = 1'b0;
  logic        reset_x;
  logic [31:0] ifu_inst;
  logic        ifu_valid;
  logic        ifu_ready;
  logic        stall;
  logic        exec_dup;
  logic [31:0] qed_inst;
  logic        qed_valid;
  logic        qed_is_dup;
  logic        qed_ready;
  logic [3:0]  orig_cnt;
  logic [3:0]  dup_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] I_A = 32'h00100093;
  localparam logic [31:0] I_B = 32'h00208113;
  localparam logic [31:0] I_C = 32'h002081B3;

  qed_replay_scheduler dut (
    .clk        (clk),
    .reset_x    (reset_x),
    .ifu_inst   (ifu_inst),
    .ifu_valid  (ifu_valid),
    .ifu_ready  (ifu_ready),
    .stall      (stall),
    .exec_dup   (exec_dup),
    .qed_inst   (qed_inst),
    .qed_valid  (qed_valid),
    .qed_is_dup (qed_is_dup),
    .qed_ready  (qed_ready),
    .orig_cnt   (orig_cnt),
    .dup_cnt    (dup_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_x   = 1'b0;
    ifu_valid = 1'b0;
    ifu_inst  = 32'h0;
    stall     = 1'b0;
    exec_dup  = 1'b0;
    repeat (2) @(negedge clk);
    reset_x = 1'b1;
    #1;
  endtask

  task automatic accept(input logic [31:0] inst);
    ifu_valid = 1'b1;
    ifu_inst  = inst;
    tick();
    ifu_valid = 1'b0;
  endtask

  task automatic start_dup();
    exec_dup = 1'b1;
    tick();
    exec_dup = 1'b0;
  endtask

  task automatic expect_dup(input string tag, input logic [31:0] inst, input logic [31:0] n);
    check_eq({tag, "_inst"}, qed_inst, inst);
    check_eq({tag, "_isdup"}, {31'd0, qed_is_dup}, 32'd1);
    check_eq({tag, "_dupcnt"}, {28'd0, dup_cnt}, n);
  endtask

  initial begin
    logic [31:0] data [8];

    // Reset values
    do_reset();
    check_eq("rst_inst", qed_inst, NOP);
    check_eq("rst_valid", {31'd0, qed_valid}, 32'd0);
    check_eq("rst_ready", {31'd0, qed_ready}, 32'd0);
    check_eq("rst_orig", {28'd0, orig_cnt}, 32'd0);
    check_eq("rst_dup", {28'd0, dup_cnt}, 32'd0);
    check_eq("rst_ifu_ready", {31'd0, ifu_ready}, 32'd1);

    // Basic three-instruction run
    accept(I_A);
    check_eq("t1_o1", qed_inst, I_A);
    check_eq("t1_o1_isdup", {31'd0, qed_is_dup}, 32'd0);
    accept(I_B);
    check_eq("t1_o2", qed_inst, I_B);
    accept(I_C);
    check_eq("t1_o3", qed_inst, I_C);
    check_eq("t1_orig", {28'd0, orig_cnt}, 32'd3);
    start_dup();
    check_eq("t1_gap_valid", {31'd0, qed_valid}, 32'd0);
    tick(); expect_dup("t1_d1", I_A, 32'd1);
    tick(); expect_dup("t1_d2", I_B, 32'd2);
    tick(); expect_dup("t1_d3", I_C, 32'd3);
    tick();
    check_eq("t1_done_ready", {31'd0, qed_ready}, 32'd1);
    check_eq("t1_done_valid", {31'd0, qed_valid}, 32'd0);
    check_eq("t1_done_inst", qed_inst, NOP);
    check_eq("t1_done_orig", {28'd0, orig_cnt}, 32'd3);
    check_eq("t1_done_dup", {28'd0, dup_cnt}, 32'd3);
    check_eq("t1_done_ifu_ready", {31'd0, ifu_ready}, 32'd0);

    // exec_dup with empty FIFO is ignored
    do_reset();
    exec_dup = 1'b1;
    #1;
    check_eq("t2_ifu_ready_blk", {31'd0, ifu_ready}, 32'd0);
    tick();
    exec_dup = 1'b0;
    #1;
    check_eq("t2_still_orig", {31'd0, ifu_ready}, 32'd1);
    repeat (2) tick();
    check_eq("t2_valid", {31'd0, qed_valid}, 32'd0);
    check_eq("t2_ready", {31'd0, qed_ready}, 32'd0);
    check_eq("t2_dup", {28'd0, dup_cnt}, 32'd0);

    // exec_dup beats a same-cycle fetch
    do_reset();
    accept(I_A);
    ifu_valid = 1'b1;
    ifu_inst  = I_B;
    exec_dup  = 1'b1;
    #1;
    check_eq("t3_ifu_ready", {31'd0, ifu_ready}, 32'd0);
    tick();
    ifu_valid = 1'b0;
    exec_dup  = 1'b0;
    check_eq("t3_orig", {28'd0, orig_cnt}, 32'd1);
    check_eq("t3_gap_valid", {31'd0, qed_valid}, 32'd0);
    tick(); expect_dup("t3_d1", I_A, 32'd1);
    tick();
    check_eq("t3_done_valid", {31'd0, qed_valid}, 32'd0);
    tick();
    check_eq("t3_ready", {31'd0, qed_ready}, 32'd1);
    check_eq("t3_dup_final", {28'd0, dup_cnt}, 32'd1);

    // Stall during replay
    do_reset();
    accept(I_A); accept(I_B); accept(I_C);
    start_dup();
    tick(); expect_dup("t4_d1", I_A, 32'd1);
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      expect_dup("t4_hold", I_A, 32'd1);
    end
    stall = 1'b0;
    tick(); expect_dup("t4_d2", I_B, 32'd2);
    tick(); expect_dup("t4_d3", I_C, 32'd3);
    tick();
    tick();
    check_eq("t4_ready", {31'd0, qed_ready}, 32'd1);

    // Full FIFO, run twice so each pass wraps both pointers from reset
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int i = 0; i < 8; i++) begin
        data[i] = 32'h10000000 + 32'(pass * 256) + 32'(i);
        accept(data[i]);
      end
      check_eq("t5_orig_full", {28'd0, orig_cnt}, 32'd8);
      ifu_valid = 1'b1;
      ifu_inst  = 32'hDEADBEEF;
      #1;
      check_eq("t5_ifu_ready_full", {31'd0, ifu_ready}, 32'd0);
      tick();
      ifu_valid = 1'b0;
      check_eq("t5_no_accept", {28'd0, orig_cnt}, 32'd8);
      check_eq("t5_gap_valid", {31'd0, qed_valid}, 32'd0);
`ifndef QED_AUTO_DUP_EN
      tick();
      check_eq("t5_wait_valid", {31'd0, qed_valid}, 32'd0);
      check_eq("t5_wait_dup", {28'd0, dup_cnt}, 32'd0);
      start_dup();
`endif
      for (int i = 0; i < 8; i++) begin
        tick();
        expect_dup("t5_pop", data[i], 32'(i + 1));
      end
      tick();
      tick();
      check_eq("t5_ready", {31'd0, qed_ready}, 32'd1);
      check_eq("t5_dup_final", {28'd0, dup_cnt}, 32'd8);
    end

    // Asynchronous reset mid-replay
    do_reset();
    for (int i = 0; i < 5; i++) accept(32'h20000000 + 32'(i));
    start_dup();
    tick(); tick();
    expect_dup("t6_d2", 32'h20000001, 32'd2);
    #2;
    reset_x = 1'b0;
    #1;
    check_eq("t6_inst", qed_inst, NOP);
    check_eq("t6_valid", {31'd0, qed_valid}, 32'd0);
    check_eq("t6_isdup", {31'd0, qed_is_dup}, 32'd0);
    check_eq("t6_orig", {28'd0, orig_cnt}, 32'd0);
    check_eq("t6_dup", {28'd0, dup_cnt}, 32'd0);
    @(negedge clk);
    reset_x = 1'b1;
    #1;
    check_eq("t6_orig_state", {31'd0, ifu_ready}, 32'd1);
    accept(I_C);
    start_dup();
    tick(); expect_dup("t6_fresh", I_C, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
